// File: rtl/uart_pkg.sv
// UART shared types and helpers.
// Receive FSM states and word-length encodings.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } rx_state_e;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    // Number of data bits for a word-length select code.
    function automatic logic [3:0] wls_to_bits(input logic [1:0] w);
        return 4'd5 + {2'b00, w};
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for the async serial input.
// Resets to 1 so an idle line never looks like a start edge.
module uart_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic pclk,
    input  logic preset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    // Shift the async input through the flop chain.
    always_ff @(posedge pclk) begin
        if (preset) ff <= '1;
        else        ff <= {ff[SYNC_STAGES-2:0], d};
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_shifter.sv
// UART receive shift register stage.
// Oversamples rxd, frames the character, reports status.
module uart_rx_shifter
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int OSR         = 16
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic       rxd,
    input  logic       baud_tick,
    input  logic [1:0] wls,
    input  logic       pen,
    input  logic       eps,
    input  logic       sp,
    output logic [7:0] rsr_data,
    output logic       receive_done,
    output logic       frame_error,
    output logic       parity_error,
    output logic       uart_break,
    output logic       rx_busy
);

    localparam int CW = $clog2(OSR);
    localparam logic [CW-1:0] CNT_MID  = CW'(OSR / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OSR - 1);

    logic rxs;
    logic rxs_d;
    logic fall;

    rx_state_e state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0] bit_idx, bit_idx_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic [1:0] wls_q, wls_nxt;
    logic pen_q, pen_nxt;
    logic eps_q, eps_nxt;
    logic sp_q, sp_nxt;
    logic par_err, par_err_nxt;
    logic par_bit, par_bit_nxt;

    logic [7:0] data_nxt;
    logic done_nxt;
    logic ferr_nxt;
    logic perr_nxt;
    logic brk_nxt;

    logic bit_last;
    logic exp_par;
    logic is_brk;

    uart_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .pclk  (pclk),
        .preset(preset),
        .d     (rxd),
        .q     (rxs)
    );

    assign fall     = rxs_d & ~rxs;
    assign bit_last = ({1'b0, bit_idx} == wls_to_bits(wls_q) - 4'd1);
    assign exp_par  = sp_q ? ~eps_q : (eps_q ? ^shreg : ~^shreg);
    assign is_brk   = ~rxs && (shreg == 8'h00) && (!pen_q || !par_bit);
    assign rx_busy  = (state != IDLE);

    // Next-state, datapath and status decode for the framing FSM.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        wls_nxt     = wls_q;
        pen_nxt     = pen_q;
        eps_nxt     = eps_q;
        sp_nxt      = sp_q;
        par_err_nxt = par_err;
        par_bit_nxt = par_bit;
        data_nxt    = rsr_data;
        done_nxt    = 1'b0;
        ferr_nxt    = frame_error;
        perr_nxt    = parity_error;
        brk_nxt     = uart_break;
        unique case (state)
            IDLE: begin
                if (fall) begin
                    state_nxt   = START;
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                    shreg_nxt   = '0;
                    wls_nxt     = wls;
                    pen_nxt     = pen;
                    eps_nxt     = eps;
                    sp_nxt      = sp;
                    par_err_nxt = 1'b0;
                    par_bit_nxt = 1'b0;
                end
            end
            START: begin
                if (baud_tick) begin
                    if (cnt == CNT_MID) begin
                        cnt_nxt     = '0;
                        bit_idx_nxt = '0;
                        state_nxt   = rxs ? IDLE : DATA;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (cnt == CNT_LAST) begin
                        cnt_nxt            = '0;
                        shreg_nxt[bit_idx] = rxs;
                        if (bit_last) state_nxt = pen_q ? PARITY : STOP;
                        else          bit_idx_nxt = bit_idx + 3'd1;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    if (cnt == CNT_LAST) begin
                        cnt_nxt     = '0;
                        par_bit_nxt = rxs;
                        par_err_nxt = (rxs != exp_par);
                        state_nxt   = STOP;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (cnt == CNT_LAST) begin
                        cnt_nxt  = '0;
                        done_nxt = 1'b1;
                        ferr_nxt = ~rxs;
                        perr_nxt = par_err;
                        brk_nxt  = is_brk;
                        data_nxt = is_brk ? 8'h00 : shreg;
                        state_nxt = is_brk ? BRK_WAIT : IDLE;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            BRK_WAIT: begin
                if (rxs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge pclk) begin
        if (preset) begin
            rxs_d        <= 1'b1;
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            wls_q        <= WLS_5;
            pen_q        <= 1'b0;
            eps_q        <= 1'b0;
            sp_q         <= 1'b0;
            par_err      <= 1'b0;
            par_bit      <= 1'b0;
            rsr_data     <= '0;
            receive_done <= 1'b0;
            frame_error  <= 1'b0;
            parity_error <= 1'b0;
            uart_break   <= 1'b0;
        end else begin
            rxs_d        <= rxs;
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            bit_idx      <= bit_idx_nxt;
            shreg        <= shreg_nxt;
            wls_q        <= wls_nxt;
            pen_q        <= pen_nxt;
            eps_q        <= eps_nxt;
            sp_q         <= sp_nxt;
            par_err      <= par_err_nxt;
            par_bit      <= par_bit_nxt;
            rsr_data     <= data_nxt;
            receive_done <= done_nxt;
            frame_error  <= ferr_nxt;
            parity_error <= perr_nxt;
            uart_break   <= brk_nxt;
        end
    end

endmodule

// File: tb/tb_uart_rx_shifter.sv
// Testbench for uart_rx_shifter.
// Directed frames with a scoreboard queue and a receive monitor.
module tb_uart_rx_shifter;

    localparam int TDIV = 4;
    localparam int BIT_CLKS = 16 * TDIV;

    logic       pclk;
    logic       preset;
    logic       rxd;
    logic       baud_tick;
    logic [1:0] wls;
    logic       pen;
    logic       eps;
    logic       sp;
    logic [7:0] rsr_data;
    logic       receive_done;
    logic       frame_error;
    logic       parity_error;
    logic       uart_break;
    logic       rx_busy;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
        logic       brk;
    } exp_t;

    exp_t sb[$];
    int checks;
    int errors;
    int done_cnt;

    uart_rx_shifter #(
        .SYNC_STAGES(2),
        .OSR        (16)
    ) dut (
        .pclk        (pclk),
        .preset      (preset),
        .rxd         (rxd),
        .baud_tick   (baud_tick),
        .wls         (wls),
        .pen         (pen),
        .eps         (eps),
        .sp          (sp),
        .rsr_data    (rsr_data),
        .receive_done(receive_done),
        .frame_error (frame_error),
        .parity_error(parity_error),
        .uart_break  (uart_break),
        .rx_busy     (rx_busy)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // One baud_tick every TDIV clocks, driven on the falling edge.
    initial begin
        int tdiv;
        tdiv = 0;
        baud_tick = 1'b0;
        forever begin
            @(negedge pclk);
            tdiv = (tdiv + 1) % TDIV;
            baud_tick = (tdiv == 0);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pop the scoreboard on every receive_done.
    always @(negedge pclk) begin
        if (receive_done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got data %0h expected none",
                         rsr_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsr_data", {24'h0, rsr_data}, {24'h0, e.d});
                chk("frame_error", {31'h0, frame_error}, {31'h0, e.fe});
                chk("parity_error", {31'h0, parity_error}, {31'h0, e.pe});
                chk("uart_break", {31'h0, uart_break}, {31'h0, e.brk});
            end
        end
    end

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (BIT_CLKS) @(negedge pclk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits,
                              input logic has_par, input logic par,
                              input logic stop);
        logic [7:0] v;
        v = d;
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(v[i]);
        if (has_par) send_bit(par);
        send_bit(stop);
        rxd = 1'b1;
        repeat (BIT_CLKS) @(negedge pclk);
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic fe,
                                input logic pe, input logic brk);
        exp_t e;
        e.d = d;
        e.fe = fe;
        e.pe = pe;
        e.brk = brk;
        return e;
    endfunction

    initial begin
        int snap;
        int waited;
        checks = 0;
        errors = 0;
        done_cnt = 0;
        preset = 1'b1;
        rxd = 1'b1;
        wls = 2'b11;
        pen = 1'b0;
        eps = 1'b0;
        sp = 1'b0;
        repeat (4) @(negedge pclk);
        preset = 1'b0;
        @(negedge pclk);

        chk("reset_busy", {31'h0, rx_busy}, 32'h0);
        chk("reset_data", {24'h0, rsr_data}, 32'h0);
        chk("reset_done", {31'h0, receive_done}, 32'h0);
        chk("reset_fe", {31'h0, frame_error}, 32'h0);
        chk("reset_pe", {31'h0, parity_error}, 32'h0);
        chk("reset_brk", {31'h0, uart_break}, 32'h0);
        repeat (BIT_CLKS) @(negedge pclk);

        // 8N1 0xA5
        sb.push_back(mk(8'hA5, 1'b0, 1'b0, 1'b0));
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);

        // 5E1, good then bad parity
        wls = 2'b00;
        pen = 1'b1;
        eps = 1'b1;
        sp = 1'b0;
        sb.push_back(mk(8'h16, 1'b0, 1'b0, 1'b0));
        send_frame(8'h16, 5, 1'b1, 1'b1, 1'b1);
        sb.push_back(mk(8'h16, 1'b0, 1'b1, 1'b0));
        send_frame(8'h16, 5, 1'b1, 1'b0, 1'b1);

        // Stick parity forced 0 (eps=1), bit sent 1 -> error
        sp = 1'b1;
        sb.push_back(mk(8'h16, 1'b0, 1'b1, 1'b0));
        send_frame(8'h16, 5, 1'b1, 1'b1, 1'b1);
        sp = 1'b0;

        // Framing error, not a break
        wls = 2'b11;
        pen = 1'b0;
        sb.push_back(mk(8'h3C, 1'b1, 1'b0, 1'b0));
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0);

        // Break: line low for three character times
        snap = done_cnt;
        sb.push_back(mk(8'h00, 1'b1, 1'b0, 1'b1));
        rxd = 1'b0;
        repeat (30 * BIT_CLKS) @(negedge pclk);
        chk("break_done_once", done_cnt - snap, 32'd1);
        chk("break_busy", {31'h0, rx_busy}, 32'h1);
        rxd = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge pclk);
        chk("break_idle", {31'h0, rx_busy}, 32'h0);
        chk("break_no_more", done_cnt - snap, 32'd1);

        // Short glitch: false start
        snap = done_cnt;
        rxd = 1'b0;
        repeat (3 * TDIV) @(negedge pclk);
        rxd = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge pclk);
        chk("glitch_no_done", done_cnt - snap, 32'd0);
        chk("glitch_idle", {31'h0, rx_busy}, 32'h0);

        // Reset in the middle of a data bit
        snap = done_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        repeat (BIT_CLKS / 2) @(negedge pclk);
        chk("pre_reset_busy", {31'h0, rx_busy}, 32'h1);
        preset = 1'b1;
        rxd = 1'b1;
        @(negedge pclk);
        chk("mid_reset_busy", {31'h0, rx_busy}, 32'h0);
        chk("mid_reset_fe", {31'h0, frame_error}, 32'h0);
        chk("mid_reset_brk", {31'h0, uart_break}, 32'h0);
        chk("mid_reset_data", {24'h0, rsr_data}, 32'h0);
        preset = 1'b0;
        repeat (2 * BIT_CLKS) @(negedge pclk);
        chk("mid_reset_no_done", done_cnt - snap, 32'd0);

        sb.push_back(mk(8'h55, 1'b0, 1'b0, 1'b0));
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);

        waited = 0;
        while (sb.size() != 0 && waited < 4 * BIT_CLKS) begin
            @(negedge pclk);
            waited++;
        end
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
